kamikaze_decode_pipe: RTL and testbench
=======================================

KAMIKAZE_DECODE_PIPE -- requirements
Module: kamikaze_decode_pipe

Interface
REQ-001 SHALL have parameter ENABLE_M, default 0, meaning RV32M opcodes decode as legal when 1.
REQ-002 SHALL have parameter ENABLE_SYSTEM, default 1, meaning ECALL/EBREAK/CSR*/FENCE decode as legal when 1.
REQ-003 SHALL have port clk_i  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_i  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush_i  in  1  discard the held and incoming instruction.
REQ-006 SHALL have port instr_i  in  32  fetched instruction word.
REQ-007 SHALL have port pc_i  in  32  address of instr_i.
REQ-008 SHALL have port is_compressed_instr_i  in  1  instruction was expanded from RVC.
REQ-009 SHALL have port instr_valid_i  in  1  instr_i/pc_i valid.
REQ-010 SHALL have port instr_ready_o  out  1  decoder accepts this cycle.
REQ-011 SHALL have port decode_valid_o  out  1  decoded outputs valid.
REQ-012 SHALL have port decode_ready_i  in  1  downstream accepts decoded outputs.
REQ-013 SHALL have ports rf_rs1_o, rf_rs2_o, rf_rd_o  out  5 each  register addresses.
REQ-014 SHALL have ports rs1_used_o, rs2_used_o, rd_we_o  out  1 each  operand use / writeback enable.
REQ-015 SHALL have port imm_o  out  32  sign-extended immediate.
REQ-016 SHALL have port alu_op_o  out  4  ALU/MUL operation code (package enum).
REQ-017 SHALL have port fu_sel_o  out  3  unit: ALU, BRANCH, JUMP, LSU, MUL, SYS.
REQ-018 SHALL have port illegal_o  out  1  instruction illegal.
REQ-019 SHALL have ports pc_o  out  32 and is_compressed_o  out  1  passthrough of captured values.

Function
REQ-020 SHALL implement one registered stage: latency exactly 1 cycle from accept to decode_valid_o.
REQ-021 SHALL drive instr_ready_o = !decode_valid_o || decode_ready_i, combinationally, with no dependence on instr_valid_i.
REQ-022 SHALL capture on instr_valid_i && instr_ready_o; decode_valid_o clears when decode_ready_i is high and nothing is captured.
REQ-023 SHALL hold every output stable while decode_valid_o && !decode_ready_i.
REQ-024 SHALL, on flush_i, clear decode_valid_o next cycle and ignore any same-cycle capture; flush has priority over accept.
REQ-025 SHALL decode opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM.
REQ-026 SHALL form imm_o per format: I=instr[31:20], S={[31:25],[11:7]}, B={[31],[7],[30:25],[11:8],0}, U={[31:12],12'b0}, J={[31],[19:12],[20],[30:21],0}; all sign-extended from bit 31; R-type imm_o=0.
REQ-027 SHALL set rs1_used_o for all formats except U/J; rs2_used_o only for R/S/B.
REQ-028 SHALL set rd_we_o only for formats with rd and rd!=0.
REQ-029 SHALL flag illegal_o for: instr[1:0]!=2'b11; unknown opcode; illegal funct3/funct7 (incl. SLLI/SRLI/SRAI shamt-field funct7); OP funct7=0000001 when ENABLE_M=0; SYSTEM/MISC-MEM when ENABLE_SYSTEM=0.
REQ-030 SHALL still assert decode_valid_o for illegal instructions, with rd_we_o=0, rs1_used_o=0, rs2_used_o=0, fu_sel_o=SYS.

Reset
REQ-031 SHALL on rst_i asynchronously clear decode_valid_o, illegal_o, rd_we_o, rs1_used_o, rs2_used_o, and zero rf_*_o, imm_o, alu_op_o, fu_sel_o, pc_o, is_compressed_o.
REQ-032 SHALL, when rst_i asserts mid-stall, drop the held instruction; first capture possible the cycle after deassertion.

Structure
REQ-033 SHALL place opcode constants, alu_op and fu_sel encodings in the shared riscv_defines include.
REQ-034 SHALL split immediate generation into combinational sub-module kamikaze_imm_gen.
REQ-035 SHALL contain no other sub-modules.

Verification
REQ-036 ADDI x5,x1,-1 (0xFFF08293) accepted, ready high -> next cycle valid, rd=5, rs1=1, imm=0xFFFFFFFF, rd_we=1.
REQ-037 BEQ x1,x2,-4 (0xFE208EE3) with decode_ready_i low 3 cycles -> outputs stable, instr_ready_o low, imm=0xFFFFFFFC, rs2_used=1.
REQ-038 MUL 0x02208033 with ENABLE_M=0 -> illegal_o=1, rd_we=0; ENABLE_M=1 -> legal, fu_sel=MUL.
REQ-039 flush_i with instr_valid_i high and a held instruction -> decode_valid_o=0 next cycle, nothing captured.
REQ-040 back-to-back valid with decode_ready_i=1 -> one decode per cycle, pc_o tracks pc_i one cycle late.
REQ-041 rst_i pulsed mid-stall -> all outputs zero immediately, no instruction lost state after release.

Source files
------------

// File: rtl/kamikaze_decode_pipe_pkg.sv
// Shared RV32 decode definitions: opcode constants, ALU/MUL/unit encodings
// and the immediate-format selector used by the decode stage.
package kamikaze_decode_pipe_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_SLL = 4'd2,  ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4,  ALU_XOR  = 4'd5,  ALU_SRL = 4'd6,  ALU_SRA = 4'd7,
    ALU_OR   = 4'd8,  ALU_AND  = 4'd9,  ALU_EQ  = 4'd10, ALU_NE  = 4'd11,
    ALU_GE   = 4'd12, ALU_GEU  = 4'd13
  } alu_op_e;

  // Interpreted on the same 4-bit bus when the unit select is FU_MUL.
  typedef enum logic [3:0] {
    MUL_MUL = 4'd0, MUL_MULH = 4'd1, MUL_MULHSU = 4'd2, MUL_MULHU = 4'd3,
    MUL_DIV = 4'd4, MUL_DIVU = 4'd5, MUL_REM    = 4'd6, MUL_REMU  = 4'd7
  } mul_op_e;

  typedef enum logic [2:0] {
    FU_ALU = 3'd0, FU_BRANCH = 3'd1, FU_JUMP = 3'd2,
    FU_LSU = 3'd3, FU_MUL    = 3'd4, FU_SYS  = 3'd5
  } fu_sel_e;

  typedef enum logic [2:0] {
    FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
    FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1_used;
    logic        rs2_used;
    logic        rd_we;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic [2:0]  fu_sel;
    logic        illegal;
  } decode_t;

  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_from_f3 = ALU_ADD;
    case (f3)
      3'd0: alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
      3'd1: alu_from_f3 = ALU_SLL;
      3'd2: alu_from_f3 = ALU_SLT;
      3'd3: alu_from_f3 = ALU_SLTU;
      3'd4: alu_from_f3 = ALU_XOR;
      3'd5: alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
      3'd6: alu_from_f3 = ALU_OR;
      3'd7: alu_from_f3 = ALU_AND;
      default: alu_from_f3 = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/kamikaze_decode_pipe_imm_gen.sv
// Combinational immediate generator: selects and sign-extends the
// immediate field of a 32-bit instruction according to its format.
module kamikaze_imm_gen
  import kamikaze_decode_pipe_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [2:0]  fmt_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (imm_fmt_e'(fmt_i))
      FMT_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      FMT_U: imm_o = {instr_i[31:12], 12'b0};
      FMT_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/kamikaze_decode_pipe.sv
// Single registered RV32I(+M) decode stage with valid/ready handshake,
// flush, and a held output register that stays stable under backpressure.
module kamikaze_decode_pipe
  import kamikaze_decode_pipe_pkg::*;
#(
  parameter bit ENABLE_M      = 1'b0,
  parameter bit ENABLE_SYSTEM = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        is_compressed_instr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  output logic        decode_valid_o,
  input  logic        decode_ready_i,
  output logic [4:0]  rf_rs1_o,
  output logic [4:0]  rf_rs2_o,
  output logic [4:0]  rf_rd_o,
  output logic        rs1_used_o,
  output logic        rs2_used_o,
  output logic        rd_we_o,
  output logic [31:0] imm_o,
  output logic [3:0]  alu_op_o,
  output logic [2:0]  fu_sel_o,
  output logic        illegal_o,
  output logic [31:0] pc_o,
  output logic        is_compressed_o
);

  logic        valid_q, valid_d;
  decode_t     dec_q, dec_d;
  logic [31:0] pc_q;
  logic        comp_q;
  logic        accept;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        legal;
  imm_fmt_e    fmt;
  fu_sel_e     fu;
  logic [3:0]  op;
  logic [31:0] imm_w;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];

  assign instr_ready_o = !valid_q || decode_ready_i;
  assign accept        = instr_valid_i && instr_ready_o && !flush_i;

  always_comb begin
    legal = 1'b0;
    fmt   = FMT_R;
    fu    = FU_SYS;
    op    = ALU_ADD;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin legal = 1'b1; fmt = FMT_U; fu = FU_ALU; end
      OPC_JAL:  begin legal = 1'b1;        fmt = FMT_J; fu = FU_JUMP; end
      OPC_JALR: begin legal = (f3 == 3'd0); fmt = FMT_I; fu = FU_JUMP; end
      OPC_BRANCH: begin
        legal = (f3 != 3'd2) && (f3 != 3'd3);
        fmt   = FMT_B;
        fu    = FU_BRANCH;
        case (f3)
          3'd0: op = ALU_EQ;
          3'd1: op = ALU_NE;
          3'd4: op = ALU_SLT;
          3'd5: op = ALU_GE;
          3'd6: op = ALU_SLTU;
          3'd7: op = ALU_GEU;
          default: op = ALU_ADD;
        endcase
      end
      OPC_LOAD:  begin legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; fmt = FMT_I; fu = FU_LSU; end
      OPC_STORE: begin legal = f3 inside {3'd0, 3'd1, 3'd2};             fmt = FMT_S; fu = FU_LSU; end
      OPC_OP_IMM: begin
        // Shift-immediates reuse the funct7 slot of the immediate field.
        if (f3 == 3'd1)      legal = (f7 == F7_BASE);
        else if (f3 == 3'd5) legal = (f7 == F7_BASE) || (f7 == F7_ALT);
        else                 legal = 1'b1;
        fmt = FMT_I;
        fu  = FU_ALU;
        op  = alu_from_f3(f3, instr_i[30] && (f3 == 3'd5));
      end
      OPC_OP: begin
        fmt = FMT_R;
        if (f7 == F7_MUL) begin
          legal = ENABLE_M;
          fu    = FU_MUL;
          op    = mul_op_e'({1'b0, f3});
        end else begin
          legal = (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == 3'd0) || (f3 == 3'd5)));
          fu    = FU_ALU;
          op    = alu_from_f3(f3, instr_i[30]);
        end
      end
      OPC_MISCMEM: begin legal = ENABLE_SYSTEM && (f3 == 3'd0); fmt = FMT_I; fu = FU_SYS; end
      OPC_SYSTEM: begin
        // funct3==0 admits only the exact ECALL/EBREAK encodings.
        if (f3 == 3'd0) legal = ENABLE_SYSTEM && (instr_i[31:21] == '0) && (instr_i[19:7] == '0);
        else            legal = ENABLE_SYSTEM && (f3 != 3'd4);
        fmt = FMT_I;
        fu  = FU_SYS;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      fmt = FMT_R;
      fu  = FU_SYS;
      op  = ALU_ADD;
    end
  end

  kamikaze_imm_gen u_imm_gen (
    .instr_i (instr_i),
    .fmt_i   (fmt),
    .imm_o   (imm_w)
  );

  always_comb begin
    dec_d          = '0;
    dec_d.rs1      = instr_i[19:15];
    dec_d.rs2      = instr_i[24:20];
    dec_d.rd       = instr_i[11:7];
    dec_d.rs1_used = legal && (fmt != FMT_U) && (fmt != FMT_J);
    dec_d.rs2_used = legal && (fmt inside {FMT_R, FMT_S, FMT_B});
    dec_d.rd_we    = legal && (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (instr_i[11:7] != 5'd0);
    dec_d.imm      = imm_w;
    dec_d.alu_op   = op;
    dec_d.fu_sel   = fu;
    dec_d.illegal  = !legal;
  end

  always_comb begin
    valid_d = valid_q;
    if (flush_i)             valid_d = 1'b0;
    else if (accept)         valid_d = 1'b1;
    else if (decode_ready_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
      pc_q    <= '0;
      comp_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        dec_q  <= dec_d;
        pc_q   <= pc_i;
        comp_q <= is_compressed_instr_i;
      end
    end
  end

  assign decode_valid_o  = valid_q;
  assign rf_rs1_o        = dec_q.rs1;
  assign rf_rs2_o        = dec_q.rs2;
  assign rf_rd_o         = dec_q.rd;
  assign rs1_used_o      = dec_q.rs1_used;
  assign rs2_used_o      = dec_q.rs2_used;
  assign rd_we_o         = dec_q.rd_we;
  assign imm_o           = dec_q.imm;
  assign alu_op_o        = dec_q.alu_op;
  assign fu_sel_o        = dec_q.fu_sel;
  assign illegal_o       = dec_q.illegal;
  assign pc_o            = pc_q;
  assign is_compressed_o = comp_q;

endmodule

// File: tb/tb_kamikaze_decode_pipe.sv
// Bench for kamikaze_decode_pipe: two instances (M on / SYSTEM off) share
// stimulus and are checked every cycle against a behavioural decode model.
module tb_kamikaze_decode_pipe;
  import kamikaze_decode_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0, flush = 1'b0, valid = 1'b0, comp = 1'b0, dready = 1'b0;
  logic [31:0] instr = '0, pc = '0;

  logic        rdy0, dv0, u10, u20, we0, ill0, c0;
  logic [4:0]  rs10, rs20, rd0;
  logic [31:0] imm0, pco0;
  logic [3:0]  alu0;
  logic [2:0]  fu0;
  logic        rdy1, dv1, u11, u21, we1, ill1, c1;
  logic [4:0]  rs11, rs21, rd1;
  logic [31:0] imm1, pco1;
  logic [3:0]  alu1;
  logic [2:0]  fu1;

  always #5 clk = ~clk;

  kamikaze_decode_pipe dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .instr_i(instr), .pc_i(pc),
    .is_compressed_instr_i(comp), .instr_valid_i(valid), .instr_ready_o(rdy0),
    .decode_valid_o(dv0), .decode_ready_i(dready), .rf_rs1_o(rs10), .rf_rs2_o(rs20),
    .rf_rd_o(rd0), .rs1_used_o(u10), .rs2_used_o(u20), .rd_we_o(we0), .imm_o(imm0),
    .alu_op_o(alu0), .fu_sel_o(fu0), .illegal_o(ill0), .pc_o(pco0), .is_compressed_o(c0));

  kamikaze_decode_pipe #(.ENABLE_M(1'b1), .ENABLE_SYSTEM(1'b0)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .instr_i(instr), .pc_i(pc),
    .is_compressed_instr_i(comp), .instr_valid_i(valid), .instr_ready_o(rdy1),
    .decode_valid_o(dv1), .decode_ready_i(dready), .rf_rs1_o(rs11), .rf_rs2_o(rs21),
    .rf_rd_o(rd1), .rs1_used_o(u11), .rs2_used_o(u21), .rd_we_o(we1), .imm_o(imm1),
    .alu_op_o(alu1), .fu_sel_o(fu1), .illegal_o(ill1), .pc_o(pco1), .is_compressed_o(c1));

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        rs1u, rs2u, rdwe, ill;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [2:0]  fu;
  } exp_t;

  int unsigned n_chk = 0, n_err = 0;
  bit          mv = 1'b0;
  exp_t        e0, e1;
  logic [31:0] mpc = '0;
  logic        mcomp = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference decode built from the ISA field rules with plain arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] i, input bit men, input bit sen);
    exp_t e;
    logic [6:0]  opc = i[6:0];
    logic [2:0]  f3  = i[14:12];
    logic [6:0]  f7  = i[31:25];
    logic [31:0] iI, iS, iB, iU, iJ, imm;
    bit ok = 0, u1 = 0, u2 = 0, wr = 0;
    logic [2:0] fu = FU_SYS;
    logic [3:0] alu = ALU_ADD;
    logic [3:0] tab [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    logic [3:0] btab[8] = '{ALU_EQ, ALU_NE, ALU_ADD, ALU_ADD, ALU_SLT, ALU_GE, ALU_SLTU, ALU_GEU};
    iI  = $signed(i) >>> 20;
    iS  = (iI & ~32'h1F) | 32'(i[11:7]);
    iB  = (i[31] ? 32'hFFFFF000 : 32'h0) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
    iU  = i & 32'hFFFFF000;
    iJ  = (i[31] ? 32'hFFF00000 : 32'h0) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
    imm = 32'h0;
    case (opc)
      7'h37, 7'h17: begin ok = 1; imm = iU; wr = 1; fu = FU_ALU; end
      7'h6F: begin ok = 1; imm = iJ; wr = 1; fu = FU_JUMP; end
      7'h67: begin ok = (f3 == 0); imm = iI; u1 = 1; wr = 1; fu = FU_JUMP; end
      7'h63: begin ok = (f3 != 2 && f3 != 3); imm = iB; u1 = 1; u2 = 1; fu = FU_BRANCH; alu = btab[f3]; end
      7'h03: begin ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5); imm = iI; u1 = 1; wr = 1; fu = FU_LSU; end
      7'h23: begin ok = (f3 <= 2); imm = iS; u1 = 1; u2 = 1; fu = FU_LSU; end
      7'h13: begin
        ok  = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
        imm = iI; u1 = 1; wr = 1; fu = FU_ALU;
        alu = (f3 == 5 && f7 == 7'h20) ? ALU_SRA : tab[f3];
      end
      7'h33: begin
        u1 = 1; u2 = 1; wr = 1;
        if (f7 == 7'h01) begin ok = men; fu = FU_MUL; alu = 4'(f3); end
        else begin
          ok  = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
          fu  = FU_ALU;
          alu = (f7 == 7'h20) ? ((f3 == 0) ? ALU_SUB : ALU_SRA) : tab[f3];
        end
      end
      7'h0F: begin ok = sen && (f3 == 0); imm = iI; u1 = 1; wr = 1; fu = FU_SYS; end
      7'h73: begin
        ok  = sen && ((f3 == 0) ? (i == 32'h00000073 || i == 32'h00100073) : (f3 != 4));
        imm = iI; u1 = 1; wr = 1; fu = FU_SYS;
      end
      default: ok = 0;
    endcase
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
    if (ok) begin
      e.rs1u = u1; e.rs2u = u2; e.rdwe = wr && (i[11:7] != 0);
      e.imm = imm; e.alu = alu; e.fu = fu; e.ill = 0;
    end else begin
      e.rs1u = 0; e.rs2u = 0; e.rdwe = 0;
      e.imm = 0; e.alu = ALU_ADD; e.fu = FU_SYS; e.ill = 1;
    end
    return e;
  endfunction

  task automatic compare_all();
    chk("ready0", rdy0, !mv || dready);
    chk("ready1", rdy1, !mv || dready);
    chk("valid0", dv0, mv);
    chk("valid1", dv1, mv);
    if (mv) begin
      chk("rs1_0", rs10, e0.rs1);   chk("rs2_0", rs20, e0.rs2);   chk("rd_0", rd0, e0.rd);
      chk("u1_0", u10, e0.rs1u);    chk("u2_0", u20, e0.rs2u);    chk("we_0", we0, e0.rdwe);
      chk("imm_0", imm0, e0.imm);   chk("alu_0", alu0, e0.alu);   chk("fu_0", fu0, e0.fu);
      chk("ill_0", ill0, e0.ill);   chk("pc_0", pco0, mpc);       chk("c_0", c0, mcomp);
      chk("rs1_1", rs11, e1.rs1);   chk("rs2_1", rs21, e1.rs2);   chk("rd_1", rd1, e1.rd);
      chk("u1_1", u11, e1.rs1u);    chk("u2_1", u21, e1.rs2u);    chk("we_1", we1, e1.rdwe);
      chk("imm_1", imm1, e1.imm);   chk("alu_1", alu1, e1.alu);   chk("fu_1", fu1, e1.fu);
      chk("ill_1", ill1, e1.ill);   chk("pc_1", pco1, mpc);       chk("c_1", c1, mcomp);
    end
  endtask

  // Advance the model with the currently driven inputs, then one clock.
  task automatic tick();
    bit mready = !mv || dready;
    if (rst || flush) mv = 0;
    else if (valid && mready) begin
      mv = 1; e0 = ref_decode(instr, 0, 1); e1 = ref_decode(instr, 1, 0);
      mpc = pc; mcomp = comp;
    end else if (dready) mv = 0;
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dv"}, {dv1, dv0}, 2'b00);
    chk({tag, "_pc"}, pco0 | pco1, 32'h0);
    chk({tag, "_imm"}, imm0 | imm1, 32'h0);
    chk({tag, "_flags"}, {we0, u10, u20, ill0, c0, we1, u11, u21, ill1, c1}, 10'h0);
    chk({tag, "_fields"}, {rs10, rs20, rd0, alu0, fu0}, 22'h0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs[11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    logic [6:0] f7;
    int unsigned sel = $urandom % 16;
    if (sel == 0) return $urandom;
    if (sel == 1) return 32'h00000073;
    if (sel == 2) return 32'h00100073;
    case ($urandom % 4)
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opcs[$urandom % 11]};
  endfunction

  localparam logic [31:0] ADDI = 32'hFFF08293;
  localparam logic [31:0] BEQ  = 32'hFE208EE3;
  localparam logic [31:0] MUL  = 32'h02208033;

  initial begin
    exp_t p;
    // model pins
    p = ref_decode(ADDI, 0, 1); chk("model_addi_imm", p.imm, 32'hFFFFFFFF);
    p = ref_decode(BEQ, 0, 1);  chk("model_beq_imm", p.imm, 32'hFFFFFFFC);
    p = ref_decode(MUL, 0, 1);  chk("model_mul_ill", p.ill, 1'b1);

    #2 rst = 1;
    #1 chk_zero("reset");
    @(posedge clk); @(posedge clk); #3 rst = 0;

    // ADDI x5,x1,-1
    valid = 1; instr = ADDI; pc = 32'h100; dready = 1; tick();
    chk("addi_v", dv0, 1); chk("addi_rd", rd0, 5); chk("addi_rs1", rs10, 1);
    chk("addi_imm", imm0, 32'hFFFFFFFF); chk("addi_we", we0, 1);
    valid = 0; tick();

    // BEQ held under backpressure
    valid = 1; instr = BEQ; pc = 32'h104; dready = 0; tick();
    instr = ADDI; pc = 32'h108;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("beq_ready", rdy0, 0); chk("beq_imm", imm0, 32'hFFFFFFFC);
      chk("beq_rs2u", u20, 1); chk("beq_pc", pco0, 32'h104);
    end
    valid = 0; dready = 1; tick();

    // MUL with and without the M extension
    valid = 1; instr = MUL; pc = 32'h110; tick();
    chk("mul_ill0", ill0, 1); chk("mul_we0", we0, 0); chk("mul_fu0", fu0, FU_SYS);
    chk("mul_ill1", ill1, 0); chk("mul_fu1", fu1, FU_MUL);
    valid = 0; tick();

    // flush beats a same-cycle capture
    valid = 1; instr = ADDI; pc = 32'h200; dready = 0; tick();
    flush = 1; instr = MUL; pc = 32'h204; tick();
    chk("flush_v", dv0, 0);
    flush = 0; valid = 0; dready = 1; tick();
    chk("flush_nocap", dv0, 0);

    // back-to-back stream
    for (int k = 0; k < 4; k++) begin
      valid = 1; instr = ADDI; pc = 32'h300 + 32'(4 * k); tick();
      chk("b2b_pc", pco0, 32'h300 + 32'(4 * k)); chk("b2b_v", dv0, 1);
    end
    valid = 0; tick();

    // reset pulsed mid-stall
    valid = 1; instr = BEQ; pc = 32'h400; dready = 0; tick();
    valid = 0; tick();
    #2 rst = 1;
    #1 chk_zero("rst_stall"); mv = 0;
    valid = 1; instr = ADDI; pc = 32'h500; tick();
    chk("rst_nocap", dv0, 0);
    #2 rst = 0;
    tick();
    chk("rst_after_v", dv0, 1); chk("rst_after_pc", pco0, 32'h500);
    valid = 0; dready = 1; tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      valid  = ($urandom % 4) != 0;
      dready = ($urandom % 3) != 0;
      flush  = ($urandom % 20) == 0;
      comp   = 1'($urandom);
      instr  = rand_instr();
      pc     = $urandom & 32'hFFFFFFFE;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
